midori64_share_io: RTL and testbench

Load/unload sequencer for the second-order masked Midori64 encryption core (3 shares). It collects plaintext and key shares from a 64-bit valid/ready stream and presents them in parallel to the core. It then issues the one-cycle start pulse that drives the round controller's start/reset input, waits for the controller's `done`, and streams the three ciphertext shares out. It sits directly upstream and downstream of the round controller/datapath pair.

---
 rtl/midori64_share_io.sv | 151 +++++++++++++++
 tb/tb_midori64_share_io.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/midori64_share_io.sv
// rtl/midori64_share_io.sv - share load/unload sequencer for the 3-share masked Midori64 core
// Optional RUN-state watchdog enabled by defining MIDORI_IO_TIMEOUT_EN.
module midori64_share_io #(
    parameter int SHARES         = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [63:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [64*SHARES-1:0]      core_pt_shares,
    output logic [128*SHARES-1:0]     core_key_shares,
    output logic                      core_start,
    input  logic                      core_done,
    input  logic [64*SHARES-1:0]      core_ct_shares,
    output logic [63:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;

    logic [2:0]              state;
    logic [3:0]              widx;
    logic [64*SHARES-1:0]    pt_q;
    logic [128*SHARES-1:0]   key_q;
    logic [64*SHARES-1:0]    ct_q;

    logic       in_fire;
    logic       out_fire;
    logic [3:0] wsel;
    logic [3:0] kidx;
    logic [7:0] pt_off;
    logic [8:0] key_off;
    logic [7:0] ct_off;
    logic       run_timeout;

    assign in_ready   = (state == S_IDLE) || (state == S_LOAD);
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = (state == S_UNLOAD);
    assign out_fire   = out_valid && out_ready;
    assign core_start = (state == S_START);
    assign busy       = (state != S_IDLE);

    // IDLE always writes word 0, whatever widx holds.
    assign wsel    = (state == S_IDLE) ? 4'd0 : widx;
    assign kidx    = wsel - 4'd3;
    assign pt_off  = {wsel[1:0], 6'b0};
    // Even key words carry the high half of a share, odd ones the low half.
    assign key_off = {kidx[2:1], ~kidx[0], 6'b0};
    assign ct_off  = {widx[1:0], 6'b0};

    assign core_pt_shares  = pt_q;
    assign core_key_shares = key_q;
    assign out_data        = out_valid ? ct_q[ct_off +: 64] : 64'd0;

`ifdef MIDORI_IO_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
    logic       error_q;

    assign run_timeout = (state == S_RUN) && !core_done && (tmo_cnt == TMO_LAST);
    assign error       = error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= 8'd0;
            error_q <= 1'b0;
        end else begin
            if (state == S_START)
                tmo_cnt <= 8'd0;
            else if (state == S_RUN && !core_done)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (state == S_IDLE && in_fire)
                error_q <= 1'b0;
            else if (run_timeout)
                error_q <= 1'b1;
        end
    end
`else
    assign run_timeout = 1'b0;
    assign error       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            widx  <= 4'd0;
            pt_q  <= '0;
            key_q <= '0;
            ct_q  <= '0;
        end else begin
            if (in_fire) begin
                if (wsel < 4'd3)
                    pt_q[pt_off +: 64] <= in_data;
                else
                    key_q[key_off +: 64] <= in_data;
            end
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        widx  <= 4'd1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        if (widx == 4'd8) begin
                            widx  <= 4'd0;
                            state <= S_START;
                        end else begin
                            widx <= widx + 4'd1;
                        end
                    end
                end
                S_START: state <= S_RUN;
                S_RUN: begin
                    if (core_done) begin
                        ct_q  <= core_ct_shares;
                        state <= S_UNLOAD;
                    end else if (run_timeout) begin
                        state <= S_IDLE;
                    end
                end
                S_UNLOAD: begin
                    if (out_fire) begin
                        if (widx == 4'd2) begin
                            widx  <= 4'd0;
                            state <= S_IDLE;
                        end else begin
                            widx <= widx + 4'd1;
                        end
                    end
                end
                default: begin
                    widx  <= 4'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midori64_share_io.sv
// tb/tb_midori64_share_io.sv - randomized self-checking bench for midori64_share_io
module tb_midori64_share_io;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [63:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [191:0] core_pt_shares;
    logic [383:0] core_key_shares;
    logic         core_start;
    logic         core_done;
    logic [191:0] core_ct_shares;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         error;

    midori64_share_io #(.SHARES(3), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_pt_shares(core_pt_shares), .core_key_shares(core_key_shares),
        .core_start(core_start), .core_done(core_done), .core_ct_shares(core_ct_shares),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0]  words [9];
    logic [191:0] exp_pt;
    logic [383:0] exp_key;

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Expected register image straight from the load-order rules.
    task automatic build_model();
        for (int s = 0; s < 3; s++) begin
            exp_pt[64*s +: 64]   = words[s];
            exp_key[128*s +: 128] = {words[3+2*s], words[4+2*s]};
        end
    endtask

    task automatic send_word(input logic [63:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_wait", 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_load(input bit gaps, input int first);
        for (int i = first; i < 9; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = rnd64();
                @(negedge clk);
            end
            send_word(words[i]);
        end
        build_model();
        check("load_pt", core_pt_shares, exp_pt);
        check("load_key", core_key_shares, exp_key);
    endtask

    task automatic run_unload(input int run_cycles, input logic [191:0] ct,
                              input int stall_share, input int stall_len);
        logic any_bad;
        check("start_pulse", core_start, 1'b1);
        check("start_in_ready", in_ready, 1'b0);
        check("start_busy", busy, 1'b1);
        in_valid  = 1'b1;
        in_data   = rnd64();
        core_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        core_done = 1'b0;
        check("start_one_cycle", core_start, 1'b0);
        any_bad = 1'b0;
        for (int i = 0; i < run_cycles; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rnd64();
            if (out_valid || in_ready || core_start) any_bad = 1'b1;
            @(negedge clk);
        end
        check("run_quiet", any_bad, 1'b0);
        in_valid       = 1'b0;
        core_done      = 1'b1;
        core_ct_shares = ct;
        @(negedge clk);
        core_done      = 1'b0;
        core_ct_shares = {rnd64(), rnd64(), rnd64()};
        check("hold_pt", core_pt_shares, exp_pt);
        check("hold_key", core_key_shares, exp_key);
        for (int k = 0; k < 3; k++) begin
            if (k == stall_share) begin
                out_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_data", out_data, ct[64*k +: 64]);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check("out_valid", out_valid, 1'b1);
            check("out_data", out_data, ct[64*k +: 64]);
            @(negedge clk);
        end
        check("end_valid", out_valid, 1'b0);
        check("end_in_ready", in_ready, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_error", error, 1'b0);
    endtask

    task automatic rand_words();
        for (int i = 0; i < 9; i++) words[i] = rnd64();
    endtask

    initial begin
        reset_n        = 1'b0;
        in_data        = '0;
        in_valid       = 1'b0;
        core_done      = 1'b0;
        core_ct_shares = '0;
        out_ready      = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_start", core_start, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_pt", core_pt_shares, 192'd0);
        check("rst_key", core_key_shares, 384'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed load 0x1..0x9, done after 32 RUN cycles.
        for (int i = 0; i < 9; i++) words[i] = 64'(i + 1);
        do_load(1'b0, 0);
        check("dir_pt", core_pt_shares, {64'h3, 64'h2, 64'h1});
        check("dir_key0", core_key_shares[127:0], {64'h4, 64'h5});
        run_unload(32, {64'hC, 64'hB, 64'hA}, -1, 0);

        // Back-pressure on share 1 for 5 cycles.
        rand_words();
        do_load(1'b0, 0);
        run_unload(10, {rnd64(), rnd64(), rnd64()}, 1, 5);

        // in_valid gaps every other cycle.
        rand_words();
        do_load(1'b1, 0);
        run_unload(20, {rnd64(), rnd64(), rnd64()}, -1, 0);

        // Reset in the middle of a load.
        rand_words();
        for (int i = 0; i < 5; i++) send_word(words[i]);
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_pt", core_pt_shares, 192'd0);
        check("abort_key", core_key_shares, 384'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rand_words();
        do_load(1'b0, 0);
        run_unload(5, {rnd64(), rnd64(), rnd64()}, -1, 0);

        for (int t = 0; t < 6; t++) begin
            rand_words();
            do_load(1'($urandom_range(0, 1)), 0);
            run_unload(int'($urandom_range(0, 40)), {rnd64(), rnd64(), rnd64()},
                       int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
        end

`ifdef MIDORI_IO_TIMEOUT_EN
        begin
            logic saw_valid;
            rand_words();
            do_load(1'b0, 0);
            check("tmo_start", core_start, 1'b1);
            @(negedge clk);
            saw_valid = 1'b0;
            for (int i = 0; i < 64; i++) begin
                if (out_valid || !busy) saw_valid = 1'b1;
                @(negedge clk);
            end
            check("tmo_run_held", saw_valid, 1'b0);
            check("tmo_error", error, 1'b1);
            check("tmo_busy", busy, 1'b0);
            check("tmo_out_valid", out_valid, 1'b0);
            rand_words();
            send_word(words[0]);
            check("tmo_error_clear", error, 1'b0);
            do_load(1'b0, 1);
            run_unload(3, {rnd64(), rnd64(), rnd64()}, -1, 0);
        end
`else
        rand_words();
        do_load(1'b0, 0);
        run_unload(100, {rnd64(), rnd64(), rnd64()}, -1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
